// File: rtl/cordic_prerotate.sv
// Front-end for the iterative CORDIC core: folds any angle into [-90, +90) by an
// exact quarter-turn pre-rotation, delivered through a 2-stage elastic pipeline.
module cordic_prerotate #(
    parameter int WIDTH = 16,
    parameter int ZW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_x,
    input  logic [WIDTH-1:0] s_y,
    input  logic [ZW-1:0]    s_z,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_x,
    output logic [WIDTH-1:0] m_y,
    output logic [ZW-1:0]    m_z,
    output logic [1:0]       m_quad,
    output logic [CNT_W-1:0] fold_cnt,
    input  logic             clr_cnt
);

    localparam logic [ZW-1:0]    QUARTER = {2'b01, {(ZW-2){1'b0}}};
    localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};

    logic             v1, v2;
    logic [WIDTH-1:0] x1, y1;
    logic [ZW-1:0]    z1;
    logic [WIDTH-1:0] fx, fy;
    logic [ZW-1:0]    fz;
    logic             ld1, ld2, fold_hs;

    // The only negation that overflows is the most negative value; clamp it.
    function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] a);
        return (a == SMIN) ? SMAX : -a;
    endfunction

    assign ld2     = !v2 || m_ready;
    assign ld1     = !v1 || ld2;
    assign s_ready = !rst && ld1;
    assign m_valid = v2;
    assign fold_hs = v2 && m_ready && (m_quad[1] ^ m_quad[0]);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        fx = x1;
        fy = y1;
        fz = z1;
        case (z1[ZW-1:ZW-2])
            2'b01: begin
                fx = sat_neg(y1);
                fy = x1;
                fz = z1 - QUARTER;
            end
            2'b10: begin
                fx = y1;
                fy = sat_neg(x1);
                fz = z1 + QUARTER;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            x1       <= '0;
            y1       <= '0;
            z1       <= '0;
            m_x      <= '0;
            m_y      <= '0;
            m_z      <= '0;
            m_quad   <= '0;
            fold_cnt <= '0;
        end else begin
            if (ld1) begin
                v1 <= s_valid;
                if (s_valid) begin
                    x1 <= s_x;
                    y1 <= s_y;
                    z1 <= s_z;
                end
            end
            // Output registers only change when the core side is free to take new data.
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    m_x    <= fx;
                    m_y    <= fy;
                    m_z    <= fz;
                    m_quad <= z1[ZW-1:ZW-2];
                end
            end
            if (clr_cnt) begin
                fold_cnt <= '0;
            end else if (fold_hs && (fold_cnt != {CNT_W{1'b1}})) begin
                fold_cnt <= fold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed + random bench for cordic_prerotate; a queue-based scoreboard checks every
// m-side handshake and the fold counter (also on a CNT_W=4 instance for saturation).
module tb_cordic_prerotate;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] z;
        logic [1:0]  q;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst, s_valid, m_ready, clr_cnt;
    logic [15:0] s_x, s_y;
    logic [31:0] s_z;
    logic        s_ready, m_valid;
    logic [15:0] m_x, m_y, fold_cnt;
    logic [31:0] m_z;
    logic [1:0]  m_quad;

    logic        sat_s_ready, sat_m_valid;
    logic [15:0] sat_m_x, sat_m_y;
    logic [31:0] sat_m_z;
    logic [1:0]  sat_m_quad;
    logic [3:0]  sat_cnt;

    txn_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   model_cnt = 0;

    always #5 clk = ~clk;

    cordic_prerotate u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_quad(m_quad),
        .fold_cnt(fold_cnt), .clr_cnt(clr_cnt)
    );

    cordic_prerotate #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sat_s_ready),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .m_valid(sat_m_valid), .m_ready(m_ready),
        .m_x(sat_m_x), .m_y(sat_m_y), .m_z(sat_m_z), .m_quad(sat_m_quad),
        .fold_cnt(sat_cnt), .clr_cnt(clr_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] neg(input logic [15:0] a);
        int v;
        v = -int'($signed(a));
        if (v > 32767) v = 32767;
        return 16'(v);
    endfunction

    function automatic txn_t model(input logic [15:0] x, input logic [15:0] y, input logic [31:0] z);
        txn_t t;
        t.q = z[31:30];
        t.x = x;
        t.y = y;
        t.z = z;
        if (t.q == 2'b01) begin
            t.x = neg(y);
            t.y = x;
            t.z = z - 32'h4000_0000;
        end else if (t.q == 2'b10) begin
            t.x = y;
            t.y = neg(x);
            t.z = z + 32'h4000_0000;
        end
        return t;
    endfunction

    // Scoreboard: pop/compare on m-side handshakes, push on s-side handshakes.
    always @(negedge clk) begin
        txn_t e;
        if (rst) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            check("fold_cnt", fold_cnt, model_cnt);
            check("fold_cnt_sat4", sat_cnt, (model_cnt > 15) ? 15 : model_cnt);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", m_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("m_x", m_x, e.x);
                    check("m_y", m_y, e.y);
                    check("m_z", m_z, e.z);
                    check("m_quad", m_quad, e.q);
                    if (!clr_cnt && (e.q == 2'b01 || e.q == 2'b10) && model_cnt < 65535)
                        model_cnt++;
                end
            end
            if (clr_cnt) model_cnt = 0;
            if (s_valid && s_ready) sb.push_back(model(s_x, s_y, s_z));
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [31:0] z);
        bit done = 0;
        s_x = x;
        s_y = y;
        s_z = z;
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) done = 1;
        end
        if (!done) check("send_timeout", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    initial begin
        txn_t ea;
        int   sent, cycles;
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; clr_cnt = 1'b0;
        s_x = '0; s_y = '0; s_z = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_x", m_x, 0);
        check("rst_m_z", m_z, 0);
        check("rst_m_quad", m_quad, 0);
        check("rst_fold_cnt", fold_cnt, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Pass-through with 2-cycle latency
        send(16'h1000, 16'h0000, 32'h2000_0000);
        check("lat_c1_m_valid", m_valid, 0);
        @(posedge clk); #1;
        check("lat_c2_m_valid", m_valid, 1);
        check("pass_m_x", m_x, 16'h1000);
        check("pass_m_z", m_z, 32'h2000_0000);
        drain("pass_drain");

        // Folds, saturating negation and quadrant boundaries
        send(16'h0100, 16'h0200, 32'h6000_0000);
        send(16'h8000, 16'h0010, 32'hA000_0000);
        send(16'h1234, 16'h8000, 32'h4000_0000);
        send(16'h1234, 16'h5678, 32'hC000_0000);
        send(16'h0001, 16'h0002, 32'hBFFF_FFFF);
        drain("fold_drain");

        // Backpressure: two buffered, third stalls, outputs held
        m_ready = 1'b0;
        ea = model(16'h0011, 16'h0022, 32'h1000_0000);
        s_valid = 1'b1; s_x = 16'h0011; s_y = 16'h0022; s_z = 32'h1000_0000;
        @(negedge clk); check("bp_rdy_a", s_ready, 1);
        @(posedge clk); #1; s_x = 16'h0033; s_y = 16'h0044; s_z = 32'h5000_0000;
        @(negedge clk); check("bp_rdy_b", s_ready, 1);
        @(posedge clk); #1; s_x = 16'h0055; s_y = 16'h0066; s_z = 32'h9000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rdy_c_low", s_ready, 0);
            check("bp_m_valid", m_valid, 1);
            check("bp_hold_x", m_x, ea.x);
            check("bp_hold_z", m_z, ea.z);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_rdy_rise", s_ready, 1);
        check("bp_out1", m_valid, 1);
        @(posedge clk); #1; s_valid = 1'b0;
        @(negedge clk); check("bp_out2", m_valid, 1);
        @(negedge clk); check("bp_out3", m_valid, 1);
        @(negedge clk); check("bp_empty", m_valid, 0);
        @(posedge clk); #1;
        check("bp_all_out", sb.size(), 0);

        // Random streaming with random handshakes and occasional clears
        sent = 0;
        cycles = 0;
        while (sent < 1000 && cycles < 20000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            clr_cnt = ($urandom_range(0, 99) == 0);
            s_x = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            s_y = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            s_z = $urandom;
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cycles++;
        end
        clr_cnt = 1'b0;
        check("stream_sent", sent, 1000);
        drain("stream_drain");

        // Counter saturation on the 4-bit instance
        clr_cnt = 1'b1;
        @(posedge clk); #1; clr_cnt = 1'b0;
        check("clr_fold_cnt", fold_cnt, 0);
        for (int i = 0; i < 20; i++)
            send(16'(i), 16'(i + 7), (i % 2 == 0) ? 32'h7000_0000 : 32'h8800_0000);
        drain("sat_drain");
        @(posedge clk); #1;
        check("sat_cnt_15", sat_cnt, 15);
        check("fold_cnt_20", fold_cnt, 20);

        // Reset with both stages full
        m_ready = 1'b0;
        send(16'h0101, 16'h0202, 32'h6000_0000);
        send(16'h0303, 16'h0404, 32'h1000_0000);
        check("full_m_valid", m_valid, 1);
        rst = 1'b1;
        @(negedge clk); check("midrst_s_ready", s_ready, 0);
        @(posedge clk); #1; rst = 1'b0;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_fold_cnt", fold_cnt, 0);
        m_ready = 1'b1;
        send(16'h0707, 16'h0808, 32'hE000_0000);
        check("post_rst_c1", m_valid, 0);
        @(posedge clk); #1;
        check("post_rst_c2", m_valid, 1);
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cordic_prerotate.md
Name: cordic_prerotate

Overview:
- Front-end stage that sits directly upstream of the iterative CORDIC rotation core.
- Accepts rotation requests (x, y, angle z) on a valid/ready handshake.
- Folds any full-circle angle into the core's convergence range (±90°) by an exact ±90° pre-rotation of the vector.
- Presents the folded operands to the core through a 2-stage elastic pipeline, with full backpressure.

Parameters:
WIDTH, 16, width of signed two's-complement x/y operands
ZW, 32, width of angle; binary angle format, 2^ZW = 360°, so 0x4000_0000 = +90° at ZW=32
CNT_W, 16, width of fold statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  request valid
s_ready  out  1  request accepted when s_valid & s_ready
s_x  in  WIDTH  signed input x
s_y  in  WIDTH  signed input y
s_z  in  ZW  input angle (signed binary angle)
m_valid  out  1  folded operands valid toward core
m_ready  in  1  core accepts operands (core idle/load)
m_x  out  WIDTH  folded x, feeds core x_i
m_y  out  WIDTH  folded y, feeds core y_i
m_z  out  ZW  folded angle, feeds core z_i
m_quad  out  2  original quadrant bits s_z[ZW-1:ZW-2], carried with the data
fold_cnt  out  CNT_W  count of folded transactions, saturating
clr_cnt  in  1  synchronous clear of fold_cnt

Behaviour:
- Reset is synchronous and active-high on rst, clock clk.
- Reset values: both stage valid bits = 0; all data registers = 0; m_valid = 0; m_x = m_y = m_z = 0; m_quad = 0; fold_cnt = 0.
- s_ready = 0 while rst is high.
- Stage 1 (capture):
  - Register s_x, s_y, s_z. Set v1 on handshake.
  - Loads when !v1 or stage 2 is loading.
- Stage 2 (fold): registers the folded result. Quadrant q = z[ZW-1:ZW-2].
  - q = 00 or 11 (angle in [-90°, +90°)): pass through unchanged.
  - q = 01 (+90° to +180°): x' = -y, y' = x, z' = z - 2^(ZW-2).
  - q = 10 (-180° to -90°): x' = y, y' = -x, z' = z + 2^(ZW-2).
  - z arithmetic is modulo 2^ZW.
  - Negation saturates: -(-2^(WIDTH-1)) = 2^(WIDTH-1)-1. No other saturation.
  - Stage 2 loads when !v2 or m_ready.
- Handshake:
  - s_ready = !rst & (!v1 | !v2 | m_ready). This is a combinational pass of m_ready; no other comb path from inputs to outputs.
  - m_valid = v2.
  - m_x, m_y, m_z, m_quad hold stable while m_valid & !m_ready.
  - Once asserted, m_valid stays high until the handshake completes.
- Latency: 2 cycles from an s-side handshake to m_valid, when not stalled.
- Throughput: 1 transaction per cycle with m_ready held high.
- Buffering:
  - With m_ready low, exactly 2 transactions are buffered; s_ready then drops.
  - s_ready reasserts in the same cycle m_ready rises.
- Simultaneous events:
  - Stage 2 drain and stage 1 advance in the same cycle is legal and loses no data.
  - Stage 1 load and advance in the same cycle is legal and loses no data.
- fold_cnt:
  - +1 on each m-side handshake whose m_quad is 01 or 10.
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority over increment in the same cycle.
- Reset mid-operation: all in-flight transactions are dropped. m_valid is 0 the cycle after rst is sampled high. Nothing is emitted for requests accepted before reset.
- Ordering: strict FIFO. No reordering, duplication or loss.

Test Plan:
- Pass-through: m_ready=1, send x=0x1000, y=0x0000, z=0x2000_0000 (45°) -> m_x=0x1000, m_y=0, m_z=0x2000_0000, m_quad=00, m_valid high exactly 2 cycles after the handshake; fold_cnt stays 0.
- Q2 fold: send x=0x0100, y=0x0200, z=0x6000_0000 (135°) -> m_x=0xFE00, m_y=0x0100, m_z=0x2000_0000, m_quad=01; fold_cnt=1.
- Q3 fold with saturation:
  - Send x=0x8000, y=0x0010, z=0xA000_0000 (-135°) -> m_x=0x0010, m_y=0x7FFF, m_z=0xE000_0000, m_quad=10.
  - Boundary: z=0x4000_0000 -> folds to m_z=0; z=0xC000_0000 -> passes through unchanged.
- Backpressure:
  - Hold m_ready=0 and push 3 requests back-to-back -> s_ready deasserts after 2 are accepted; m outputs stay stable.
  - Raise m_ready -> all 3 emerge in order, one per cycle, no loss or duplication.
- Streaming: 1000 random requests, random s_valid/m_ready toggling -> the m-side sequence matches the reference model exactly. fold_cnt equals the number of folded quadrants; verify saturation by forcing CNT_W=4 with 20 folds -> 15.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle m_valid=0 and fold_cnt=0; s_ready low during rst; the first post-reset request emerges with 2-cycle latency.
